// File: rtl/fcpu_pkg.sv
// Shared CPU-wide definitions for the result/broadcast datapath.
//   RSV_ID_W : width of a reservation-station / ROB destination tag
//   DATA_W   : width of a result value
//   CDB_W    : width of one common-data-bus payload {tag, data}
//   cdb_t    : packed view of a CDB payload, used by the broadcaster and
//              by every block that snoops the bus
package fcpu_pkg;

  localparam int RSV_ID_W = 4;
  localparam int DATA_W   = 32;
  localparam int CDB_W    = RSV_ID_W + DATA_W;

  typedef struct packed {
    logic [RSV_ID_W-1:0] tag;
    logic [DATA_W-1:0]   data;
  } cdb_t;

  function automatic cdb_t make_cdb(input logic [RSV_ID_W-1:0] tag,
                                    input logic [DATA_W-1:0]   data);
    cdb_t r;
    r.tag  = tag;
    r.data = data;
    return r;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Small circular-buffer FIFO holding completed results for one source.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   flush     : clears pointers and count; wins over push and pop
//   push, din : write request and payload (ignored while full)
//   pop       : read request (ignored while empty); head is the oldest entry
//   full      : count == depth
//   empty     : count == 0
module result_fifo #(
  parameter int W       = 36,
  parameter int DEPTH_W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << DEPTH_W;

  logic [W-1:0]       mem [DEPTH];
  logic [DEPTH_W-1:0] wr_ptr;
  logic [DEPTH_W-1:0] rd_ptr;
  logic [DEPTH_W:0]   count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == (DEPTH_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// Transmitter side of the common data bus. Each functional unit deposits
// results into its own result_fifo; a round-robin arbiter picks one
// non-empty FIFO per cycle and its head is registered onto cdb/cdb_valid.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : per-source result valid
//   in_data    : per-source payload, slice s = in_data[s*CDB_W +: CDB_W]
//   in_ready   : per-source FIFO not full (low while rst is high)
//   flush      : discards all buffered results, keeps arbiter pointer
//   cdb_valid  : registered broadcast valid (no backpressure)
//   cdb        : registered broadcast payload {tag, data}
//
// Handshake: a source transfers a result on any rising edge where
// in_valid[s] && in_ready[s]. in_ready depends only on registered FIFO
// state (and rst), never on in_valid or on a same-cycle pop.
module cdb_broadcaster
  import fcpu_pkg::*;
#(
  parameter int N_SOURCES    = 4,
  parameter int FIFO_DEPTH_W = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_SOURCES-1:0]         in_valid,
  input  logic [N_SOURCES*CDB_W-1:0]   in_data,
  output logic [N_SOURCES-1:0]         in_ready,
  input  logic                         flush,
  output logic                         cdb_valid,
  output logic [CDB_W-1:0]             cdb
);

  localparam int PTR_W = (N_SOURCES > 1) ? $clog2(N_SOURCES) : 1;

  logic [N_SOURCES-1:0] full;
  logic [N_SOURCES-1:0] empty;
  logic [N_SOURCES-1:0] req;
  logic [N_SOURCES-1:0] pop;
  cdb_t                 head [N_SOURCES];

  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     grant_idx;
  logic [PTR_W-1:0]     cand_idx;
  logic [PTR_W-1:0]     next_ptr;
  logic                 grant_valid;
  int                   cand;

  for (genvar s = 0; s < N_SOURCES; s++) begin : g_src
    result_fifo #(
      .W       (CDB_W),
      .DEPTH_W (FIFO_DEPTH_W)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (in_valid[s] && in_ready[s]),
      .pop   (pop[s]),
      .din   (in_data[s*CDB_W +: CDB_W]),
      .head  (head[s]),
      .full  (full[s]),
      .empty (empty[s])
    );

    assign in_ready[s] = !rst && !full[s];
    assign req[s]      = !empty[s];
    // A flush cycle pops nothing; the FIFO is being cleared anyway.
    assign pop[s]      = grant_valid && (grant_idx == PTR_W'(s)) && !flush;
  end

  // Scan sources starting at rr_ptr, wrapping; first requester wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int i = 0; i < N_SOURCES; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= N_SOURCES) cand = cand - N_SOURCES;
      cand_idx = PTR_W'(cand);
      if (!grant_valid && req[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign next_ptr = (grant_idx == PTR_W'(N_SOURCES-1)) ? '0 : grant_idx + 1'b1;

  // Output register and priority pointer. cdb holds its last value when
  // idle or flushed so snoopers see a stable bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid <= 1'b0;
      cdb       <= '0;
      rr_ptr    <= '0;
    end else if (flush) begin
      cdb_valid <= 1'b0;
    end else if (grant_valid) begin
      cdb_valid <= 1'b1;
      cdb       <= head[grant_idx];
      rr_ptr    <= next_ptr;
    end else begin
      cdb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_broadcaster.sv
module tb_cdb_broadcaster;
  import fcpu_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 2;
  localparam int DEPTH = 1 << DW;

  // ---------------- clock / reset ----------------
  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       in_valid;
  logic [N*CDB_W-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               flush;
  logic               cdb_valid;
  logic [CDB_W-1:0]   cdb;

  always #5 clk = ~clk;

  cdb_broadcaster #(
    .N_SOURCES    (N),
    .FIFO_DEPTH_W (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .cdb_valid (cdb_valid),
    .cdb       (cdb)
  );

  // ---------------- checking ----------------
  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic expect_bcast(input string tag, input logic ev, input logic [CDB_W-1:0] ep);
    check({tag, "_valid"}, 64'(cdb_valid), 64'(ev));
    if (ev) check({tag, "_data"}, 64'(cdb), 64'(ep));
  endtask

  // Directed payload: tag = {s, seq}, data marks source in [15:8], seq in [7:0].
  function automatic logic [CDB_W-1:0] mk(input int s, input int seq);
    logic [RSV_ID_W-1:0] t;
    logic [DATA_W-1:0]   d;
    t = RSV_ID_W'((s * 4 + seq) & 15);
    d = 32'hA000_0000 | (DATA_W'(s) << 8) | DATA_W'(seq);
    return {t, d};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    in_valid = '0;
    in_data  = '0;
    flush    = 1'b0;
  endtask

  task automatic set_src(input int s, input logic [CDB_W-1:0] p);
    in_valid[s]                = 1'b1;
    in_data[s*CDB_W +: CDB_W]  = p;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // ---------------- scoreboard ----------------
  logic [CDB_W-1:0] exp_q[$];
  int pend[N];
  int wait_cnt[N];
  int rseq[N];
  int max_wait  = 0;
  int ready_low = 0;

  task automatic sb_monitor();
    int hit;
    int src;
    logic [CDB_W-1:0] got;
    src = -1;
    if (cdb_valid) begin
      got = cdb;
      src = int'(got[15:8]);
      hit = -1;
      foreach (exp_q[i]) if (hit < 0 && int'(exp_q[i][15:8]) == src) hit = i;
      check("sb_known", 64'(hit >= 0), 64'd1);
      if (hit >= 0) begin
        check("sb_order", 64'(got), 64'(exp_q[hit]));
        exp_q.delete(hit);
        if (src < N) pend[src]--;
      end
    end
    for (int s = 0; s < N; s++) begin
      if (pend[s] > 0 && s != src) begin
        wait_cnt[s]++;
        if (wait_cnt[s] > max_wait) max_wait = wait_cnt[s];
      end else begin
        wait_cnt[s] = 0;
      end
    end
  endtask

  logic [N-1:0]     rdy_tab [6] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h7, 4'h8};
  logic [CDB_W-1:0] single_p;
  logic [CDB_W-1:0] p;

  initial begin
    // ---- reset held 3 cycles with all valids high ----
    rst      = 1'b1;
    in_valid = '1;
    in_data  = '0;
    flush    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_valid", 64'(cdb_valid), 64'd0);
      check("rst_cdb", 64'(cdb), 64'd0);
      check("rst_ready", 64'(in_ready), 64'd0);
    end
    rst      = 1'b0;
    in_valid = '0;
    #1;
    check("ready_after_rst", 64'(in_ready), 64'hF);
    check("valid_after_rst", 64'(cdb_valid), 64'd0);
    @(negedge clk);

    // ---- single result, latency 2 ----
    single_p = {4'd5, 32'hDEADBEEF};
    set_src(2, single_p);
    @(negedge clk);
    expect_bcast("single_t1", 1'b0, '0);
    drive_idle();
    @(negedge clk);
    expect_bcast("single_t2", 1'b1, single_p);
    @(negedge clk);
    expect_bcast("single_t3", 1'b0, '0);
    check("single_hold", 64'(cdb), 64'(single_p));

    // ---- fairness from pointer 0 ----
    reset_dut();
    for (int s = 0; s < N; s++) set_src(s, mk(s, 0));
    @(negedge clk);
    expect_bcast("fair_t1", 1'b0, '0);
    drive_idle();
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      expect_bcast("fair_rr", 1'b1, mk(k, 0));
    end
    @(negedge clk);
    expect_bcast("fair_end", 1'b0, '0);
    // pointer back at 0: source 0 beats source 3
    set_src(3, mk(3, 1));
    set_src(0, mk(0, 1));
    @(negedge clk);
    expect_bcast("ptr_t1", 1'b0, '0);
    drive_idle();
    @(negedge clk);
    expect_bcast("ptr_first", 1'b1, mk(0, 1));
    @(negedge clk);
    expect_bcast("ptr_second", 1'b1, mk(3, 1));

    // ---- source 1 back-to-back, drained every cycle ----
    for (int c = 0; c < 7; c++) begin
      if (c < 5) begin
        check("b2b_ready", 64'(in_ready[1]), 64'd1);
        set_src(1, mk(1, c));
      end else begin
        drive_idle();
      end
      @(negedge clk);
      if (c >= 1 && c <= 5) expect_bcast("b2b_bcast", 1'b1, mk(1, c - 1));
      else                  expect_bcast("b2b_idle", 1'b0, '0);
    end

    // ---- full boundary: all sources push every cycle ----
    reset_dut();
    for (int c = 0; c < 21; c++) begin
      int b;
      if (c <= 5) check("full_ready", 64'(in_ready), 64'(rdy_tab[c]));
      if (c < 5) for (int s = 0; s < N; s++) set_src(s, mk(s, c));
      else       drive_idle();
      @(negedge clk);
      b = c - 1;
      if (b >= 0 && b < 16)       expect_bcast("full_round", 1'b1, mk(b % 4, b / 4));
      else if (b >= 16 && b < 19) expect_bcast("full_last", 1'b1, mk(b - 16, 4));
      else                        expect_bcast("full_idle", 1'b0, '0);
    end

    // ---- flush ----
    reset_dut();
    set_src(0, mk(0, 0));
    set_src(3, mk(3, 0));
    @(negedge clk);
    expect_bcast("fl_c2", 1'b0, '0);
    set_src(0, mk(0, 1));
    set_src(3, mk(3, 1));
    @(negedge clk);
    expect_bcast("fl_c3", 1'b1, mk(0, 0));
    drive_idle();
    set_src(0, mk(0, 2));
    flush = 1'b1;
    check("fl_ready_pre", 64'(in_ready), 64'hF);
    @(negedge clk);
    expect_bcast("fl_c4", 1'b0, '0);
    drive_idle();
    check("fl_ready_post", 64'(in_ready), 64'hF);
    @(negedge clk);
    expect_bcast("fl_c5", 1'b0, '0);
    set_src(0, mk(0, 7));
    set_src(1, mk(1, 7));
    @(negedge clk);
    expect_bcast("fl_c6", 1'b0, '0);
    drive_idle();
    @(negedge clk);
    expect_bcast("fl_ptr_kept", 1'b1, mk(1, 7));
    @(negedge clk);
    expect_bcast("fl_second", 1'b1, mk(0, 7));
    repeat (4) begin
      @(negedge clk);
      expect_bcast("fl_quiet", 1'b0, '0);
    end

    // ---- sustained random traffic against the scoreboard ----
    reset_dut();
    for (int s = 0; s < N; s++) begin
      pend[s] = 0; wait_cnt[s] = 0; rseq[s] = 0;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      sb_monitor();
      in_valid = '0;
      for (int s = 0; s < N; s++) begin
        if ($urandom_range(0, 99) < 70) begin
          p = {RSV_ID_W'($urandom_range(0, 15)), 16'(rseq[s]), 8'(s), 8'($urandom_range(0, 255))};
          set_src(s, p);
          if (in_ready[s]) begin
            exp_q.push_back(p);
            pend[s]++;
            rseq[s]++;
          end
        end
      end
      if (in_ready != '1) ready_low++;
      @(negedge clk);
    end
    for (int i = 0; i < 40; i++) begin
      sb_monitor();
      drive_idle();
      @(negedge clk);
    end
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    check("sb_wait_bound", 64'(max_wait <= N * DEPTH), 64'd1);
    check("sb_saw_full", 64'(ready_low > 0), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
